// File: rtl/shift_input_reader_if.sv
//------------------------------------------------------------------------------
// Module      : shift_input_reader_if
// Description : Serial chain pins and captured-word bus for shift_input_reader.
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

interface shift_input_reader_if #(
    parameter int WIDTH = 8
);
    logic             start;
    logic             sr_data;
    logic             sr_pl_n;
    logic             sr_clk;
    logic [WIDTH-1:0] data;
    logic             valid;
    logic             changed;
    logic             busy;

    // Reader side: samples the chain and publishes the captured word.
    modport slave (
        input  start,
        input  sr_data,
        output sr_pl_n,
        output sr_clk,
        output data,
        output valid,
        output changed,
        output busy
    );

    // Controller side: requests scans and consumes the captured word.
    modport master (
        output start,
        output sr_data,
        input  sr_pl_n,
        input  sr_clk,
        input  data,
        input  valid,
        input  changed,
        input  busy
    );
endinterface

`default_nettype wire

// File: rtl/shift_input_reader.sv
//------------------------------------------------------------------------------
// Module      : shift_input_reader
// Description : Reads a 74HC165-style PISO chain MSB first and publishes the word.
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module shift_input_reader #(
    parameter int WIDTH     = 8,
    parameter int CLK_DIV   = 1316,
    parameter int AUTO_SCAN = 0
) (
    input  logic                  clk,
    input  logic                  rst_n,
    shift_input_reader_if.slave   bus
);

    localparam int c_CW = $clog2(CLK_DIV);
    localparam int c_BW = $clog2(WIDTH + 1);

    localparam logic [c_CW-1:0] c_PHASE_LAST = c_CW'(CLK_DIV - 1);
    localparam logic [c_BW-1:0] c_BIT_LAST   = c_BW'(WIDTH - 1);
    localparam logic            c_AUTO       = (AUTO_SCAN != 0);

    localparam logic [2:0] S_IDLE     = 3'd0;
    localparam logic [2:0] S_LOAD     = 3'd1;
    localparam logic [2:0] S_SHIFT_LO = 3'd2;
    localparam logic [2:0] S_SHIFT_HI = 3'd3;
    localparam logic [2:0] S_DONE     = 3'd4;

    logic [2:0]       r_state;
    logic [c_CW-1:0]  r_phase_cnt;
    logic [c_BW-1:0]  r_bit_cnt;
    logic [WIDTH-1:0] r_shreg;
    logic [WIDTH-1:0] r_data;
    logic             r_sr_pl_n;
    logic             r_sr_clk;
    logic             r_valid;
    logic             r_changed;
    logic             r_busy;

    wire w_phase_end = (r_phase_cnt == c_PHASE_LAST);

    // Pin outputs are updated on the same edge as the state they belong to.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= S_IDLE;
            r_phase_cnt <= '0;
            r_bit_cnt   <= '0;
            r_shreg     <= '0;
            r_data      <= '0;
            r_sr_pl_n   <= 1'b1;
            r_sr_clk    <= 1'b0;
            r_valid     <= 1'b0;
            r_changed   <= 1'b0;
            r_busy      <= 1'b0;
        end else begin
            r_valid   <= 1'b0;
            r_changed <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (bus.start || c_AUTO) begin
                        r_state     <= S_LOAD;
                        r_phase_cnt <= '0;
                        r_sr_pl_n   <= 1'b0;
                        r_sr_clk    <= 1'b0;
                        r_busy      <= 1'b1;
                    end
                end
                S_LOAD: begin
                    if (w_phase_end) begin
                        r_state     <= S_SHIFT_LO;
                        r_phase_cnt <= '0;
                        r_bit_cnt   <= '0;
                        r_sr_pl_n   <= 1'b1;
                    end else begin
                        r_phase_cnt <= r_phase_cnt + c_CW'(1);
                    end
                end
                S_SHIFT_LO: begin
                    if (w_phase_end) begin
                        // Sample Q7 at the end of the low phase, well after the last shift edge.
                        r_shreg     <= {r_shreg[WIDTH-2:0], bus.sr_data};
                        r_bit_cnt   <= r_bit_cnt + c_BW'(1);
                        r_phase_cnt <= '0;
                        if (r_bit_cnt == c_BIT_LAST) begin
                            r_state <= S_DONE;
                        end else begin
                            r_state  <= S_SHIFT_HI;
                            r_sr_clk <= 1'b1;
                        end
                    end else begin
                        r_phase_cnt <= r_phase_cnt + c_CW'(1);
                    end
                end
                S_SHIFT_HI: begin
                    if (w_phase_end) begin
                        r_state     <= S_SHIFT_LO;
                        r_phase_cnt <= '0;
                        r_sr_clk    <= 1'b0;
                    end else begin
                        r_phase_cnt <= r_phase_cnt + c_CW'(1);
                    end
                end
                S_DONE: begin
                    r_data      <= r_shreg;
                    r_valid     <= 1'b1;
                    r_changed   <= (r_shreg != r_data);
                    r_busy      <= c_AUTO;
                    r_phase_cnt <= '0;
                    if (c_AUTO) begin
                        r_state   <= S_LOAD;
                        r_sr_pl_n <= 1'b0;
                    end else begin
                        r_state <= S_IDLE;
                    end
                end
                default: begin
                    r_state   <= S_IDLE;
                    r_sr_pl_n <= 1'b1;
                    r_sr_clk  <= 1'b0;
                    r_busy    <= 1'b0;
                end
            endcase
        end
    end

    assign bus.sr_pl_n = r_sr_pl_n;
    assign bus.sr_clk  = r_sr_clk;
    assign bus.data    = r_data;
    assign bus.valid   = r_valid;
    assign bus.changed = r_changed;
    assign bus.busy    = r_busy;

endmodule

`default_nettype wire

// File: tb/tb_shift_input_reader.sv
//------------------------------------------------------------------------------
// Module      : tb_shift_input_reader
// Description : Drives shift_input_reader against 74HC165 chain models.
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module tb_shift_input_reader;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst_n      = 1'b0;
    logic rst_auto_n = 1'b0;

    int n_cmp  = 0;
    int n_fail = 0;

    shift_input_reader_if #(.WIDTH(8))  b8 ();
    shift_input_reader_if #(.WIDTH(16)) b16 ();
    shift_input_reader_if #(.WIDTH(8))  ba ();

    shift_input_reader #(.WIDTH(8),  .CLK_DIV(4), .AUTO_SCAN(0)) u_dut8  (.clk(clk), .rst_n(rst_n),      .bus(b8));
    shift_input_reader #(.WIDTH(16), .CLK_DIV(2), .AUTO_SCAN(0)) u_dut16 (.clk(clk), .rst_n(rst_n),      .bus(b16));
    shift_input_reader #(.WIDTH(8),  .CLK_DIV(4), .AUTO_SCAN(1)) u_auto  (.clk(clk), .rst_n(rst_auto_n), .bus(ba));

    // 74HC165 models: PL low loads, rising CP shifts toward Q7.
    logic [7:0] par8 = 8'h00, chain8 = 8'h00;
    always @(negedge b8.sr_pl_n or posedge b8.sr_clk)
        if (!b8.sr_pl_n) chain8 <= par8;
        else             chain8 <= {chain8[6:0], 1'b0};
    assign b8.sr_data = chain8[7];

    logic [7:0] par_hi = 8'h00, par_lo = 8'h00, chip_hi = 8'h00, chip_lo = 8'h00;
    always @(negedge b16.sr_pl_n or posedge b16.sr_clk)
        if (!b16.sr_pl_n) begin
            chip_hi <= par_hi;
            chip_lo <= par_lo;
        end else begin
            chip_hi <= {chip_hi[6:0], chip_lo[7]};
            chip_lo <= {chip_lo[6:0], 1'b0};
        end
    assign b16.sr_data = chip_hi[7];

    logic [7:0] par_a = 8'h00, chain_a = 8'h00;
    always @(negedge ba.sr_pl_n or posedge ba.sr_clk)
        if (!ba.sr_pl_n) chain_a <= par_a;
        else             chain_a <= {chain_a[6:0], 1'b0};
    assign ba.sr_data = chain_a[7];

    int          sel = 0;
    logic        obs_pl, obs_clk, obs_valid, obs_changed, obs_busy;
    logic [31:0] obs_data;
    always_comb begin
        obs_pl      = b8.sr_pl_n;
        obs_clk     = b8.sr_clk;
        obs_valid   = b8.valid;
        obs_changed = b8.changed;
        obs_busy    = b8.busy;
        obs_data    = {24'h0, b8.data};
        if (sel == 1) begin
            obs_pl      = b16.sr_pl_n;
            obs_clk     = b16.sr_clk;
            obs_valid   = b16.valid;
            obs_changed = b16.changed;
            obs_busy    = b16.busy;
            obs_data    = {16'h0, b16.data};
        end
    end

    logic [31:0] prev8 = 0, prev16 = 0;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // One scan on DUT 'which'; expectations come from chain width and phase length.
    task automatic scan(input int which, input logic [31:0] word, input bit poke);
        int w, div, pl_low, pl_first, rises, vcount, voff;
        logic [31:0] vdata, prev;
        logic vchg, prev_clk;
        sel = which;
        w   = (which == 1) ? 16 : 8;
        div = (which == 1) ? 2 : 4;
        if (which == 1) {par_hi, par_lo} = word[15:0];
        else            par8 = word[7:0];
        prev = (which == 1) ? prev16 : prev8;
        if (which == 1) b16.start = 1'b1; else b8.start = 1'b1;
        tick();
        b16.start = 1'b0;
        b8.start  = 1'b0;
        check($sformatf("busy_at_start[%0d]", which), {31'h0, obs_busy}, 32'd1);
        pl_low = 0; pl_first = -1; rises = 0; vcount = 0; voff = -1;
        vdata = 0; vchg = 1'b0; prev_clk = obs_clk;
        for (int off = 0; off < 80; off++) begin
            if (off > 0) tick();
            if (!obs_pl) begin
                pl_low++;
                if (pl_first < 0) pl_first = off;
            end
            if (obs_clk && !prev_clk) rises++;
            prev_clk = obs_clk;
            if (obs_valid) begin
                vcount++;
                voff  = off;
                vdata = obs_data;
                vchg  = obs_changed;
            end
            if (poke && off == 9)  b8.start = 1'b1;
            if (poke && off == 10) b8.start = 1'b0;
        end
        check($sformatf("pl_first[%0d]", which), pl_first, 0);
        check($sformatf("pl_low_cycles[%0d]", which), pl_low, div);
        check($sformatf("sr_clk_rises[%0d]", which), rises, w - 1);
        check($sformatf("valid_pulses[%0d]", which), vcount, 1);
        check($sformatf("valid_cycle[%0d]", which), voff, 2 * w * div + 1);
        check($sformatf("data[%0d]", which), vdata, word);
        check($sformatf("changed[%0d]", which), {31'h0, vchg}, {31'h0, word != prev});
        check($sformatf("busy_after[%0d]", which), {31'h0, obs_busy}, 32'd0);
        if (which == 1) prev16 = word; else prev8 = word;
    endtask

    initial begin
        logic [31:0] word;
        logic [7:0]  exp_q[$];
        logic [7:0]  exp_a, prev_a;
        int          busy_low, vcnt;

        b8.start = 1'b0;
        b16.start = 1'b0;
        ba.start = 1'b0;
        repeat (3) tick();
        check("rst_pl_n", {31'h0, b8.sr_pl_n}, 32'd1);
        check("rst_sr_clk", {31'h0, b8.sr_clk}, 32'd0);
        check("rst_data", {24'h0, b8.data}, 32'd0);
        check("rst_valid_changed", {30'h0, b8.valid, b8.changed}, 32'd0);
        check("rst_busy", {31'h0, b8.busy}, 32'd0);
        rst_n = 1'b1;
        repeat (2) tick();
        check("idle_busy", {31'h0, b8.busy}, 32'd0);

        scan(0, 32'hA5, 1'b0);
        scan(0, 32'hA5, 1'b0);
        scan(0, 32'h5A, 1'b1);

        for (int i = 0; i < 4; i++) begin
            word = (i == 2) ? prev8 : ($urandom & 32'hFF);
            scan(0, word, 1'b0);
        end
        par8 = 8'h3C;
        scan(0, 32'h5A, 1'b0);

        // Abort during the high phase of the fourth bit.
        sel = 0;
        b8.start = 1'b1;
        tick();
        b8.start = 1'b0;
        repeat (33) tick();
        check("abort_in_shift_hi", {31'h0, b8.sr_clk}, 32'd1);
        rst_n = 1'b0;
        #1;
        check("abort_pl_n", {31'h0, b8.sr_pl_n}, 32'd1);
        check("abort_sr_clk", {31'h0, b8.sr_clk}, 32'd0);
        check("abort_data", {24'h0, b8.data}, 32'd0);
        check("abort_busy", {31'h0, b8.busy}, 32'd0);
        prev8  = 0;
        prev16 = 0;
        repeat (2) tick();
        rst_n = 1'b1;
        tick();
        scan(0, 32'hFF, 1'b0);

        scan(1, 32'h1234, 1'b0);
        for (int i = 0; i < 2; i++) scan(1, $urandom & 32'hFFFF, 1'b0);

        // Free-running scans: each word is whatever the chips held at its load.
        par_a = 8'h0F;
        prev_a = 8'h00;
        busy_low = 0;
        vcnt = 0;
        rst_auto_n = 1'b1;
        tick();
        for (int off = 0; off < 263; off++) begin
            if (off > 0) tick();
            if (!ba.busy) busy_low++;
            if (ba.valid) begin
                vcnt++;
                check("auto_valid_period", {31'h0, (off % 65 == 0)}, 32'd1);
                exp_a = exp_q.pop_front();
                check("auto_data", {24'h0, ba.data}, {24'h0, exp_a});
                check("auto_changed", {31'h0, ba.changed}, {31'h0, exp_a != prev_a});
                prev_a = exp_a;
            end
            if (off % 65 == 0) exp_q.push_back(par_a);
            if (off % 65 == 30 && $urandom_range(0, 3) != 0) par_a = par_a ^ 8'h0F;
        end
        check("auto_valid_count", vcnt, 4);
        check("auto_busy_low_cycles", busy_low, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL timeout: simulation did not complete");
        $fatal(1, "timeout");
    end

endmodule

`default_nettype wire

// File: doc/shift_input_reader.md
Name: shift_input_reader

Overview:
Serial reader for a 74HC165-style parallel-in/serial-out shift register chain (buttons, DIP switches, keypad lines). It is the input-side counterpart of the 74HC164 display output path.
- Pulses the chain's parallel-load line, clocks the bits out MSB first, and presents the captured word as a parallel register with a one-cycle valid strobe and a change flag.
- Everything runs on the system clock; the serial phase rate comes from an internal tick counter, with no derived clocks.

Parameters:
WIDTH, 8, bits in the chain (8 per cascaded chip); legal range 2..32.
CLK_DIV, 1316, system clock cycles per serial phase; must be ≥2; 1316 gives a phase rate of about 38 kHz from 50 MHz.
AUTO_SCAN, 0, when 1 a new scan starts automatically after each completed scan and start is ignored.

Ports:
clk  input  1  system clock; all state changes on its rising edge.
rst_n  input  1  asynchronous, active-low reset.
start  input  1  single-cycle request to begin a scan; honoured only in IDLE.
sr_data  input  1  serial data from the last chip's Q7.
sr_pl_n  output  1  parallel load to the chain, active low.
sr_clk  output  1  shift clock to the chain; the chain shifts on its rising edge.
data  output  WIDTH  last captured word; the first bit read is data[WIDTH-1].
valid  output  1  one-cycle strobe when data updates.
changed  output  1  one-cycle strobe, coincident with valid, when the new word differs from the previous data.
busy  output  1  scan in progress.

Behaviour:
- Reset values: sr_pl_n=1, sr_clk=0, data=0, valid=0, changed=0, busy=0, state=IDLE.
- Reset asserted mid-scan aborts the scan immediately. The partial word is discarded and data is forced to 0.
- Phase timing: phase counter width is $clog2(CLK_DIV). Every non-IDLE, non-DONE state lasts exactly CLK_DIV clk cycles; the counter clears on each state entry.
- Registered outputs: sr_pl_n and sr_clk are registered and glitch-free, each driven as a pure function of state.
- IDLE: sr_pl_n=1, sr_clk=0, busy=0.
  - start=1 (or AUTO_SCAN=1) at edge N → LOAD from edge N, with busy=1 from edge N.
- LOAD: sr_pl_n=0, sr_clk=0 for CLK_DIV cycles → SHIFT_LO.
- SHIFT_LO: sr_pl_n=1, sr_clk=0.
  - On the last cycle of the phase: shreg <= {shreg[WIDTH-2:0], sr_data} and bit_cnt increments.
  - If bit_cnt reaches WIDTH → DONE; otherwise → SHIFT_HI.
- SHIFT_HI: sr_clk=1 for CLK_DIV cycles → SHIFT_LO.
  - Exactly WIDTH-1 sr_clk rising edges occur per scan; the first bit is valid right after the load, with no clock needed.
- DONE (one clk cycle): data <= shreg, valid=1, changed=(shreg != data), busy=0.
  - Next state is IDLE, or LOAD when AUTO_SCAN=1; busy stays 1 in that case.
- Latency: valid is high in cycle N + 2·WIDTH·CLK_DIV + 1, where N is the edge that sampled start.
- data holds between scans. changed on the first scan after reset compares against 0.
- start while busy, or while in DONE, is ignored and not queued.
- valid and changed are never high for more than one consecutive cycle.
- shreg and bit_cnt are internal; bit_cnt width is $clog2(WIDTH+1).

Test Plan:
- WIDTH=8, CLK_DIV=4, bench models a 74HC165 holding 8'hA5; pulse start at edge N → sr_pl_n low for cycles N..N+3; exactly 7 sr_clk rising edges; data=8'hA5, valid=1, changed=1 at cycle N+65; busy low afterwards.
- Repeat the scan with 8'hA5 unchanged → valid=1, changed=0. Change the model to 8'h5A and scan again → data=8'h5A, changed=1.
- Pulse start again at cycle N+10 of an ongoing scan → no effect: same valid cycle, a single valid pulse, sr_pl_n low only once.
- Deassert rst_n during SHIFT_HI of bit 4 → immediately sr_pl_n=1, sr_clk=0, data=0, busy=0. After release, a fresh start with 8'hFF → data=8'hFF, changed=1.
- WIDTH=16, CLK_DIV=2, two cascaded chip models holding 16'h1234 → data=16'h1234 at start+65 cycles; 15 sr_clk edges.
- AUTO_SCAN=1, CLK_DIV=4, WIDTH=8, with start held at 0 → after reset, valid pulses every 65 cycles and busy stays 1. Toggle the model between 8'h00 and 8'h0F → changed follows each toggle.
